// File: rtl/divider_restoring_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Supports runtime signed/unsigned operation, valid/ready handshakes on both
// sides, and divide-by-zero / signed-overflow flags.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   n_in, d_in, sgn_in    dividend, divisor, 1 = two's-complement mode
//   out_valid / out_ready result handshake
//   q_out, r_out          quotient and remainder, held while out_valid=1
//   dbz_out, ovf_out      divide-by-zero and signed-overflow flags
module divider_restoring_seq #(
    parameter int unsigned WN = 8,
    parameter int unsigned WD = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] n_in,
    input  logic [WD-1:0] d_in,
    input  logic          sgn_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WN-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          dbz_out,
    output logic          ovf_out
);

    localparam int unsigned CW = (WN > 1) ? $clog2(WN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WN-1:0] nq_q, nq_d;      // dividend magnitude shifting out, quotient shifting in
    logic [WD-1:0] rem_q, rem_d;
    logic [WD-1:0] dmag_q, dmag_d;
    logic          neg_q_q, neg_q_d;
    logic          neg_r_q, neg_r_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [WN-1:0] q_out_q, q_out_d;
    logic [WD-1:0] r_out_q, r_out_d;
    logic          dbz_out_q, dbz_out_d;
    logic          ovf_out_q, ovf_out_d;

    // Operand magnitudes for signed mode
    logic          n_neg_c, d_neg_c;
    logic [WN-1:0] n_mag_c;
    logic [WD-1:0] d_mag_c;
    assign n_neg_c = sgn_in & n_in[WN-1];
    assign d_neg_c = sgn_in & d_in[WD-1];
    assign n_mag_c = n_neg_c ? WN'(-n_in) : n_in;
    assign d_mag_c = d_neg_c ? WD'(-d_in) : d_in;

    // Restoring step: shifted partial remainder and trial subtraction
    logic [WD:0] part_c, trial_c;
    logic        fits_c;
    assign part_c  = {rem_q, nq_q[WN-1]};
    assign fits_c  = (part_c >= {1'b0, dmag_q});
    assign trial_c = part_c - {1'b0, dmag_q};

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nq_d        = nq_q;
        rem_d       = rem_q;
        dmag_d      = dmag_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_out_d     = q_out_q;
        r_out_d     = r_out_q;
        dbz_out_d   = dbz_out_q;
        ovf_out_d   = ovf_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    dbz_out_d  = 1'b0;
                    ovf_out_d  = 1'b0;
                    ovf_d      = sgn_in && (n_in == {1'b1, {(WN-1){1'b0}}}) && (d_in == '1);
                    if (d_in == '0) begin
                        nq_d    = '1;
                        rem_d   = n_in[WD-1:0];
                        dbz_d   = 1'b1;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        nq_d    = n_mag_c;
                        rem_d   = '0;
                        dmag_d  = d_mag_c;
                        dbz_d   = 1'b0;
                        neg_q_d = n_neg_c ^ d_neg_c;
                        neg_r_d = n_neg_c;
                        cnt_d   = CW'(WN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                nq_d  = {nq_q[WN-2:0], fits_c};
                rem_d = fits_c ? trial_c[WD-1:0] : part_c[WD-1:0];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                // Truncating division: remainder follows the dividend's sign
                if (neg_q_q) nq_d  = WN'(-nq_q);
                if (neg_r_q) rem_d = WD'(-rem_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle publishes the result; afterwards wait for the consumer
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    q_out_d     = nq_q;
                    r_out_d     = rem_q;
                    dbz_out_d   = dbz_q;
                    ovf_out_d   = ovf_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nq_q        <= '0;
            rem_q       <= '0;
            dmag_q      <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            r_out_q     <= '0;
            dbz_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nq_q        <= nq_d;
            rem_q       <= rem_d;
            dmag_q      <= dmag_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_out_q     <= q_out_d;
            r_out_q     <= r_out_d;
            dbz_out_q   <= dbz_out_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q_out     = q_out_q;
    assign r_out     = r_out_q;
    assign dbz_out   = dbz_out_q;
    assign ovf_out   = ovf_out_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Self-checking bench for divider_restoring_seq: directed scenarios plus
// randomized operations checked against an integer-arithmetic reference.
module tb_divider_restoring_seq;

    localparam int unsigned WN = 8;
    localparam int unsigned WD = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WN-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          sgn_in;
    logic          out_valid;
    logic          out_ready;
    logic [WN-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dbz_out;
    logic          ovf_out;

    int pass_cnt = 0;
    int total    = 0;

    divider_restoring_seq #(.WN(WN), .WD(WD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .n_in     (n_in),
        .d_in     (d_in),
        .sgn_in   (sgn_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q_out    (q_out),
        .r_out    (r_out),
        .dbz_out  (dbz_out),
        .ovf_out  (ovf_out)
    );

    always #5 clk = ~clk;

    // Reference: truncating integer division with the divider's special cases
    function automatic void model(input logic [WN-1:0] n, input logic [WD-1:0] d, input logic s,
                                  output logic [WN-1:0] q, output logic [WD-1:0] r,
                                  output logic dz, output logic ov);
        int ni, di;
        dz = 1'b0;
        ov = 1'b0;
        if (d == '0) begin
            q  = '1;
            r  = n[WD-1:0];
            dz = 1'b1;
        end else if (s) begin
            ni = int'($signed(n));
            di = int'($signed(d));
            if (ni == -(2 ** (WN - 1)) && di == -1) ov = 1'b1;
            q = WN'(ni / di);
            r = WD'(ni % di);
        end else begin
            ni = int'(n);
            di = int'(d);
            q  = WN'(ni / di);
            r  = WD'(ni % di);
        end
    endfunction

    // Present one operation and measure clocks from acceptance to out_valid (-1 on timeout)
    task automatic do_op(input logic [WN-1:0] n, input logic [WD-1:0] d, input logic s,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        n_in     = n;
        d_in     = d;
        sgn_in   = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        d_in      = '0;
        sgn_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, q_out, r_out, dbz_out, ovf_out} !== '0) begin
            $display("FAIL reset_outputs: got ov=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
                     out_valid, q_out, r_out, dbz_out, ovf_out);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_unsigned();
        int lat;
        do_op(8'd200, 6'd7, 1'b0, lat);
        total++;
        if (lat !== 10) $display("FAIL unsigned_latency: got %0d, want 10", lat);
        else pass_cnt++;
        total++;
        if (q_out !== 8'h1C || r_out !== 6'd4 || dbz_out !== 1'b0 || ovf_out !== 1'b0) begin
            $display("FAIL unsigned_200_7: got q=%h r=%h dbz=%b ovf=%b, want q=1c r=04 dbz=0 ovf=0",
                     q_out, r_out, dbz_out, ovf_out);
        end else pass_cnt++;
        release_result();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL handshake_return: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_signed();
        int lat;
        do_op(8'h9C, 6'd7, 1'b1, lat);
        total++;
        if (q_out !== 8'hF2 || r_out !== 6'h3E || lat !== 10) begin
            $display("FAIL signed_neg100_7: got q=%h r=%h lat=%0d, want q=f2 r=3e lat=10", q_out, r_out, lat);
        end else pass_cnt++;
        release_result();
        do_op(8'd100, 6'h39, 1'b1, lat);
        total++;
        if (q_out !== 8'hF2 || r_out !== 6'h02 || dbz_out !== 1'b0) begin
            $display("FAIL signed_100_neg7: got q=%h r=%h dbz=%b, want q=f2 r=02 dbz=0", q_out, r_out, dbz_out);
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_div_by_zero();
        int lat;
        do_op(8'd13, 6'd0, 1'b0, lat);
        total++;
        if (lat !== 1) $display("FAIL dbz_latency: got %0d, want 1", lat);
        else pass_cnt++;
        total++;
        if (q_out !== 8'hFF || r_out !== 6'h0D || dbz_out !== 1'b1 || ovf_out !== 1'b0) begin
            $display("FAIL dbz_13_0: got q=%h r=%h dbz=%b ovf=%b, want q=ff r=0d dbz=1 ovf=0",
                     q_out, r_out, dbz_out, ovf_out);
        end else pass_cnt++;
        release_result();
        do_op(8'd9, 6'd3, 1'b0, lat);
        total++;
        if (q_out !== 8'd3 || r_out !== 6'd0 || dbz_out !== 1'b0) begin
            $display("FAIL dbz_clear_9_3: got q=%h r=%h dbz=%b, want q=03 r=00 dbz=0", q_out, r_out, dbz_out);
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        do_op(8'h80, 6'h3F, 1'b1, lat);
        total++;
        if (q_out !== 8'h80 || r_out !== 6'd0 || ovf_out !== 1'b1 || dbz_out !== 1'b0) begin
            $display("FAIL ovf_signed: got q=%h r=%h ovf=%b dbz=%b, want q=80 r=00 ovf=1 dbz=0",
                     q_out, r_out, ovf_out, dbz_out);
        end else pass_cnt++;
        release_result();
        do_op(8'h80, 6'h3F, 1'b0, lat);
        total++;
        if (q_out !== 8'd2 || r_out !== 6'd2 || ovf_out !== 1'b0) begin
            $display("FAIL ovf_unsigned: got q=%h r=%h ovf=%b, want q=02 r=02 ovf=0", q_out, r_out, ovf_out);
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_op(8'd250, 6'd9, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            n_in     = WN'($urandom);
            d_in     = WD'($urandom);
            sgn_in   = 1'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== 8'd27 || r_out !== 6'd7) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL backpressure_hold: %0d unstable cycles, want 0 (q=%h r=%h)", bad, q_out, r_out);
        else pass_cnt++;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end else pass_cnt++;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL backpressure_ignored_input: %0d bad idle cycles, want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [WN-1:0] n, eq;
        logic [WD-1:0] d, er;
        logic          s, edz, eov;
        int            lat, elat;
        for (int k = 0; k < 60; k++) begin
            n = WN'($urandom);
            d = ($urandom_range(0, 7) == 0) ? '0 : WD'($urandom);
            s = 1'($urandom);
            if (k < 4) begin
                n = 8'h80;
                d = (k[0]) ? 6'h3F : 6'h20;
                s = 1'b1;
            end
            model(n, d, s, eq, er, edz, eov);
            elat = edz ? 1 : WN + 2;
            do_op(n, d, s, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            total++;
            if (lat !== elat || q_out !== eq || r_out !== er || dbz_out !== edz || ovf_out !== eov) begin
                $display("FAIL random_%0d n=%h d=%h s=%b: got q=%h r=%h dbz=%b ovf=%b lat=%0d, want q=%h r=%h dbz=%b ovf=%b lat=%0d",
                         k, n, d, s, q_out, r_out, dbz_out, ovf_out, lat, eq, er, edz, eov, elat);
            end else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int bad;
        do_op(8'd200, 6'd7, 1'b0, lat);
        release_result();
        @(negedge clk);
        n_in     = 8'd100;
        d_in     = 6'd3;
        sgn_in   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, q_out, r_out, dbz_out, ovf_out} !== '0) begin
            $display("FAIL reset_mid_outputs: got ov=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
                     out_valid, q_out, r_out, dbz_out, ovf_out);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL reset_mid_stale: %0d cycles with stale activity, want 0", bad);
        else pass_cnt++;
        do_op(8'd255, 6'd1, 1'b0, lat);
        total++;
        if (q_out !== 8'hFF || r_out !== 6'd0 || lat !== 10) begin
            $display("FAIL reset_mid_next_255_1: got q=%h r=%h lat=%0d, want q=ff r=00 lat=10", q_out, r_out, lat);
        end else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/divider_restoring_seq.md
Name: divider_restoring_seq

Overview:
Iterative radix-2 restoring divider producing one quotient bit per clock.
- Generalises the combinational restoring divider with: runtime signed/unsigned mode, valid/ready handshakes on input and output, and divide-by-zero and overflow flags.
- Sits in datapaths where a full-array divider costs too much area and a WN+2 cycle latency is acceptable.

Parameters:
WN  8  width of dividend n and quotient q (bits)
WD  6  width of divisor d and remainder r (bits); WD <= WN

Ports:
clk        input   1   system synchronous clock, rising edge
rst_n      input   1   asynchronous active-low reset
in_valid   input   1   operands valid
in_ready   output  1   divider idle, can accept operands
n_in       input   WN  dividend
d_in       input   WD  divisor
sgn_in     input   1   1 = two's-complement operands/results, 0 = unsigned
out_valid  output  1   result valid
out_ready  input   1   consumer accepts result
q_out      output  WN  quotient
r_out      output  WD  remainder
dbz_out    output  1   divide-by-zero occurred
ovf_out    output  1   signed overflow occurred

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - in_ready=1 after reset release. out_valid=0, q_out=0, r_out=0, dbz_out=0, ovf_out=0.
  - Any operation in progress is discarded; no out_valid is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture n, d, sgn.
    - If d==0, go to DONE.
    - Otherwise go to CALC and load the iteration counter with WN-1.
  - CALC: one restoring step per cycle, exactly WN cycles. At counter 0, go to FIX.
  - FIX: one cycle of sign correction. Go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency:
  - out_valid rises WN+2 clocks after the accepting edge (WN=8: 10 clocks).
  - For divide-by-zero it rises 1 clock after the accepting edge.
  - in_ready reasserts the cycle after the out_valid & out_ready handshake. Acceptance in the same cycle as the output handshake is not supported.
- Arithmetic:
  - Signed mode: operate on magnitudes |n| (WN bits) and |d| (WD bits).
  - Partial remainder register is WD+1 bits. Each step:
    - shift the remainder left and bring in the next dividend MSB;
    - trial = remainder - |d|;
    - if trial >= 0, remainder = trial and q bit = 1; otherwise restore (keep remainder) and q bit = 0.
  - FIX, signed mode only: negate q if sign(n) XOR sign(d); negate r if n < 0. This is truncating division: r has the sign of n and |r| < |d|.
  - Unsigned mode: FIX passes values through unchanged.
- Divide by zero: q_out = all ones, r_out = n_in[WD-1:0], dbz_out=1, ovf_out=0. This applies in both modes.
- Signed overflow: n = -2^(WN-1) with d = -1 gives q_out = -2^(WN-1) (wrapped), r_out=0, ovf_out=1.
- Output stability:
  - q_out, r_out, dbz_out, ovf_out are registered and stable while out_valid=1, for as long as out_ready stays low.
  - Flags clear on the next accepted operation.
- in_valid and operand changes while in_ready=0 are ignored. Operands are sampled only at acceptance.

Test Plan:
- Unsigned, WN=8/WD=6: n=200, d=7, sgn=0 -> q=28 (0x1C), r=4; out_valid exactly 10 clocks after accept; dbz=0, ovf=0.
- Signed: n=-100 (0x9C), d=7, sgn=1 -> q=-14 (0xF2), r=-2 (6'h3E). Also n=100, d=-7 -> q=0xF2, r=2.
- Divide by zero: n=13, d=0 -> q=0xFF, r=6'h0D, dbz=1; out_valid 1 clock after accept. A following 9/3 clears dbz and gives q=3, r=0.
- Overflow: n=0x80, d=6'h3F, sgn=1 -> q=0x80, r=0, ovf=1. The same operands with sgn=0 -> q=2, r=2, ovf=0.
- Backpressure: hold out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Release -> IDLE the next cycle, in_ready=1.
- Reset mid-CALC: assert rst_n=0 at iteration 4 -> all outputs 0 immediately. After release, in_ready=1, no stale out_valid, and the next operation 255/1 (unsigned) -> q=255, r=0.
